// File: rtl/uart_pkg.sv
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART FSM state encoding and baud divisor helper.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Rounded to the nearest integer divisor.
  function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module   : uart_tx_fifo
//  Brief    : Synchronous DEPTH x 8 first-word-fall-through byte FIFO.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [7:0]    wdata,
  input  logic          rd,
  output logic [7:0]    rdata,
  output logic [AW:0]   count
);

  localparam logic [AW:0] c_full = (AW + 1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_wr_en;
  logic          w_rd_en;

  assign w_wr_en = wr && (r_count != c_full);
  assign w_rd_en = rd && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + 1'b1;
      if (w_rd_en) r_rptr <= r_rptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wptr] <= wdata;
  end

  // Head entry is always visible so the consumer can pop and load together.
  assign rdata = r_mem[r_rptr];
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_tx_buf.sv
// ============================================================================
//  Module   : uart_tx_buf
//  Brief    : Buffered UART transmitter, 8N1 (8E1 when UART_TX_PARITY_EN is
//             defined), LSB first, with sticky overflow flag.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int          DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic       rdy,
  output logic       tx,
  output logic       busy,
  output logic       ovf
);

  localparam int unsigned c_baud_div = calc_baud_div(CLK_FREQ, BAUD);
  localparam int          c_bw       = (c_baud_div > 1) ? $clog2(c_baud_div) : 1;
  localparam logic [c_bw-1:0] c_baud_last = c_bw'(c_baud_div - 1);
  localparam int          c_aw       = $clog2(DEPTH);
  localparam logic [c_aw:0] c_full    = (c_aw + 1)'(DEPTH);
  localparam logic [c_aw:0] c_rdy_max = (c_aw + 1)'(DEPTH - 2);

  uart_state_t     r_state;
  uart_state_t     w_state_nxt;
  logic [c_bw-1:0] r_baud_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shreg;
  logic [7:0]      w_shreg_nxt;
  logic            r_tx;
  logic            w_tx_nxt;
  logic            r_ovf;
  logic            w_bit_end;
  logic            w_load;
  logic            w_shift;
  logic            w_fifo_wr;
  logic            w_fifo_rd;
  logic [7:0]      w_fifo_rdata;
  logic [c_aw:0]   w_count;
  logic            w_empty;

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .AW    (c_aw)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (w_fifo_wr),
    .wdata (din),
    .rd    (w_fifo_rd),
    .rdata (w_fifo_rdata),
    .count (w_count)
  );

  assign w_empty   = (w_count == '0);
  assign w_fifo_wr = din_vld && (w_count != c_full);
  assign w_bit_end = (r_baud_cnt == c_baud_last);

`ifdef UART_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_parity <= 1'b0;
    else if (w_load) r_parity <= ^w_fifo_rdata;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_fifo_rd   = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_fifo_rd   = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift = 1'b1;
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) w_state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Chain straight into the next start bit so frames are gapless.
        if (w_bit_end) begin
          if (!w_empty) begin
            w_fifo_rd   = 1'b1;
            w_load      = 1'b1;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_shreg_nxt = r_shreg;
    if (w_load)       w_shreg_nxt = w_fifo_rdata;
    else if (w_shift) w_shreg_nxt = {1'b0, r_shreg[7:1]};

    // Line level is derived from the state being entered, then registered.
    case (w_state_nxt)
      ST_START:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = w_shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_nxt = r_parity;
`endif
      default:   w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_tx       <= 1'b1;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_tx    <= w_tx_nxt;
      if ((r_state == ST_IDLE) || w_bit_end) r_baud_cnt <= '0;
      else                                   r_baud_cnt <= r_baud_cnt + 1'b1;
      if (w_load)       r_bit_cnt <= '0;
      else if (w_shift) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (din_vld && (w_count == c_full)) r_ovf <= 1'b1;
    end
  end

  assign rdy  = (w_count <= c_rdy_max);
  assign tx   = r_tx;
  assign busy = (r_state != ST_IDLE) || !w_empty;
  assign ovf  = r_ovf;

endmodule

`default_nettype wire
